// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with the shared memory via mem_ready and traps illegal opcodes and stalls.
module legv8_multicycle_control #(
    parameter int OPCODE_W    = 11,
    parameter int MEM_TIMEOUT = 15,
    parameter int ENABLE_CBNZ = 1,
    parameter int ENABLE_B    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                reg2loc,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_nz,
    output logic                pc_src,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal,
    output logic                timeout,
    output logic [3:0]          state
);

    // state | meaning
    // FETCH 0 | read IR, PC+4 | DECODE 1 | classify, branch target | EXEC_R 2 | R-type ALU
    // ADDR 3 | address calc | WB_R 4 | ALU writeback | MEM_RD 5 / MEM_WR 6 | data access
    // BR_COND 7 | CBZ/CBNZ | BR_UNCOND 8 | B | FAULT 9 | trapped | WB_LD 10 | load writeback
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_ADDR = 4'd3,
        S_WB_R = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6, S_BR_COND = 4'd7,
        S_BR_UNCOND = 4'd8, S_FAULT = 4'd9, S_WB_LD = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_RTYPE, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_B
    } cls_t;

    localparam logic [7:0] WAIT_LIM = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d, mem_next;
    cls_t       cls_q, cls_d, dec_cls;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d, timeout_q, timeout_d;
    logic       mem_wait;
    logic [10:0] op11;

    assign op11 = opcode[OPCODE_W-1 -: 11];

    always_comb begin
        dec_cls = C_NONE;
        casez (op11)
            11'b1??0101?000: dec_cls = C_RTYPE;
            11'b11111000010: dec_cls = C_LDUR;
            11'b11111000000: dec_cls = C_STUR;
            11'b10110100???: dec_cls = C_CBZ;
            11'b10110101???: dec_cls = (ENABLE_CBNZ != 0) ? C_CBNZ : C_NONE;
            11'b000101?????: dec_cls = (ENABLE_B != 0) ? C_B : C_NONE;
            default:         dec_cls = C_NONE;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        wait_d        = wait_q;
        illegal_d     = illegal_q;
        timeout_d     = timeout_q;
        mem_wait      = 1'b0;
        mem_next      = S_FETCH;
        reg2loc       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_nz     = 1'b0;
        pc_src        = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                mem_wait = 1'b1;
                mem_next = S_DECODE;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                reg2loc   = (dec_cls == C_STUR) || (dec_cls == C_CBZ) || (dec_cls == C_CBNZ);
                cls_d     = dec_cls;
                case (dec_cls)
                    C_RTYPE:        state_d = S_EXEC_R;
                    C_LDUR, C_STUR: state_d = S_ADDR;
                    C_CBZ, C_CBNZ:  state_d = S_BR_COND;
                    C_B:            state_d = S_BR_UNCOND;
                    default: begin
                        state_d   = S_FAULT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (cls_q == C_LDUR) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                mem_wait = 1'b1;
                mem_next = S_WB_LD;
            end
            S_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                reg2loc   = 1'b1;
                mem_wait  = 1'b1;
                mem_next  = S_FETCH;
            end
            S_BR_COND: begin
                reg2loc       = 1'b1;
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
                branch_nz     = (cls_q == C_CBNZ);
                state_d       = S_FETCH;
            end
            S_BR_UNCOND: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
                state_d  = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase

        // A ready on the limit cycle wins over the timeout.
        if (mem_wait) begin
            if (mem_ready) begin
                wait_d  = 8'd0;
                state_d = mem_next;
            end else if (wait_q == WAIT_LIM) begin
                state_d   = S_FAULT;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end

        if ((state_d != state_q) &&
            ((state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR)))
            wait_d = 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule
